// File: rtl/host_lcd_sequencer.sv
// -----------------------------------------------------------------------------
// host_lcd_sequencer
//
// Purpose:
//   Drives a 16x2 HD44780-style character LCD over an 8-bit, write-only bus.
//   After reset it waits out the panel power-up time and sends the init
//   command set. It then keeps both display lines in sync with the host rows.
//   Any difference between the host rows and the last-written snapshot
//   triggers a full rewrite of both lines: 34 bytes in total.
//
// Ports:
//   clk       in   1    clock
//   nRst      in   1    asynchronous, active-low reset
//   top       in   128  line-1 characters, [127:120] = column 0 ... [7:0] = col 15
//   bottom    in   128  line-2 characters, same packing
//   lcd_rs    out  1    0 = command byte, 1 = data byte
//   lcd_rw    out  1    always 0 (write only)
//   lcd_en    out  1    enable strobe; the panel latches on its falling edge
//   lcd_data  out  8    byte on the LCD bus
//   busy      out  1    high while power-up, init or a refresh is in progress
//   ready     out  1    high once init has completed, until the next reset
//
// Every byte goes through the same three phases:
//   SETUP for 1 cycle,
//   EN for EN_CYC cycles,
//   HOLD for BYTE_CYC cycles, or CLR_CYC cycles after the clear command.
// rs/data are decoded from the sequencer position. They do not change from
// SETUP through the end of HOLD.
//
// State table:
//   state   | meaning
//   PWRUP   | waiting PWRUP_CYC cycles for the panel supply to settle
//   INIT    | sending 0x38, 0x0C, 0x01, 0x06
//   IDLE    | panel matches snapshot; watching host rows for a change
//   CMD1    | sending DDRAM address 0x80 (line 1, column 0)
//   ROW1    | sending 16 line-1 data bytes from snap_top
//   CMD2    | sending DDRAM address 0xC0 (line 2, column 0)
//   ROW2    | sending 16 line-2 data bytes from snap_bot
// -----------------------------------------------------------------------------
module host_lcd_sequencer #(
    parameter int PWRUP_CYC = 1500,
    parameter int EN_CYC    = 4,
    parameter int BYTE_CYC  = 20,
    parameter int CLR_CYC   = 800
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic [127:0] top,
    input  logic [127:0] bottom,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en,
    output logic [7:0]   lcd_data,
    output logic         busy,
    output logic         ready
);

    // One shared down-counter serves the power-up wait and every byte phase.
    // It must be wide enough for the longest of these waits.
    localparam int MAX_AB  = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
    localparam int MAX_CD  = (EN_CYC > BYTE_CYC) ? EN_CYC : BYTE_CYC;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] PWRUP_LOAD = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] EN_LOAD    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] BYTE_LOAD  = CW'(BYTE_CYC - 1);
    localparam logic [CW-1:0] CLR_LOAD   = CW'(CLR_CYC - 1);

    localparam logic [127:0] BLANK_ROW = {16{8'h20}};

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_CMD1,
        S_ROW1,
        S_CMD2,
        S_ROW2
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_EN,
        PH_HOLD
    } phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      init_idx_q, init_idx_d;
    logic [3:0]      col_q, col_d;
    logic [127:0]    snap_top_q, snap_top_d;
    logic [127:0]    snap_bot_q, snap_bot_d;
    logic            ready_q, ready_d;
    logic            force_q, force_d;
    logic            en_q, en_d;

    logic            cnt_zero;
    logic            byte_state;
    logic            byte_done;
    logic            byte_rs;
    logic [7:0]      byte_data;
    logic            is_clear;
    logic [CW-1:0]   hold_load;
    logic [6:0]      col_base;
    logic            rows_differ;

    // ------------------------------------------------------------------
    // Byte currently on the bus, derived from the sequencer position.
    // Column 0 sits in the top byte of each row. The bit offset of a
    // column is therefore (15 - col) * 8, which is {~col, 3'b000}.
    // ------------------------------------------------------------------
    assign col_base = {~col_q, 3'b000};

    always_comb begin
        byte_rs   = 1'b0;
        byte_data = 8'h00;
        case (state_q)
            S_INIT: begin
                case (init_idx_q)
                    2'd0:    byte_data = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
                    2'd1:    byte_data = 8'h0C;  // display on, cursor off
                    2'd2:    byte_data = 8'h01;  // clear display
                    default: byte_data = 8'h06;  // entry mode: increment, no shift
                endcase
            end
            S_CMD1: byte_data = 8'h80;
            S_ROW1: begin
                byte_rs   = 1'b1;
                byte_data = snap_top_q[col_base +: 8];
            end
            S_CMD2: byte_data = 8'hC0;
            S_ROW2: begin
                byte_rs   = 1'b1;
                byte_data = snap_bot_q[col_base +: 8];
            end
            default: begin
                byte_rs   = 1'b0;
                byte_data = 8'h00;
            end
        endcase
    end

    // Only the clear command needs the long settle time. A data byte that
    // happens to be 0x01 is an ordinary character.
    assign is_clear    = !byte_rs && (byte_data == 8'h01);
    assign hold_load   = is_clear ? CLR_LOAD : BYTE_LOAD;
    assign cnt_zero    = (cnt_q == '0);
    assign byte_state  = (state_q == S_INIT) || (state_q == S_CMD1) || (state_q == S_ROW1) ||
                         (state_q == S_CMD2) || (state_q == S_ROW2);
    assign byte_done   = byte_state && (phase_q == PH_HOLD) && cnt_zero;
    assign rows_differ = (top != snap_top_q) || (bottom != snap_bot_q);

    // ------------------------------------------------------------------
    // Next-state logic.
    // The byte-phase engine runs first. The state case then takes over at
    // the end of each byte and decides where the sequence goes next.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        init_idx_d = init_idx_q;
        col_d      = col_q;
        snap_top_d = snap_top_q;
        snap_bot_d = snap_bot_q;
        ready_d    = ready_q;
        force_d    = force_q;
        en_d       = en_q;

        if (byte_state) begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_EN;
                    cnt_d   = EN_LOAD;
                    en_d    = 1'b1;
                end
                PH_EN: begin
                    if (cnt_zero) begin
                        phase_d = PH_HOLD;
                        cnt_d   = hold_load;
                        en_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                PH_HOLD: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    phase_d = PH_SETUP;
                    en_d    = 1'b0;
                end
            endcase
        end

        case (state_q)
            S_PWRUP: begin
                if (cnt_zero) begin
                    state_d    = S_INIT;
                    phase_d    = PH_SETUP;
                    init_idx_d = 2'd0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_INIT: begin
                if (byte_done) begin
                    phase_d = PH_SETUP;
                    if (init_idx_q == 2'd3) begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        // The panel was just cleared. It must be rewritten
                        // even if the host rows equal the blank snapshot.
                        force_d = 1'b1;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                    end
                end
            end

            S_IDLE: begin
                phase_d = PH_SETUP;
                if (force_q || rows_differ) begin
                    // The refresh reads only the snapshot. Host changes made
                    // while it runs are picked up by the next compare in IDLE.
                    snap_top_d = top;
                    snap_bot_d = bottom;
                    force_d    = 1'b0;
                    state_d    = S_CMD1;
                end
            end

            S_CMD1: begin
                if (byte_done) begin
                    state_d = S_ROW1;
                    phase_d = PH_SETUP;
                    col_d   = 4'd0;
                end
            end

            S_ROW1: begin
                if (byte_done) begin
                    phase_d = PH_SETUP;
                    col_d   = col_q + 4'd1;
                    if (col_q == 4'd15) begin
                        state_d = S_CMD2;
                    end
                end
            end

            S_CMD2: begin
                if (byte_done) begin
                    state_d = S_ROW2;
                    phase_d = PH_SETUP;
                    col_d   = 4'd0;
                end
            end

            S_ROW2: begin
                if (byte_done) begin
                    phase_d = PH_SETUP;
                    col_d   = col_q + 4'd1;
                    if (col_q == 4'd15) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_PWRUP;
                phase_d = PH_SETUP;
                cnt_d   = PWRUP_LOAD;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= S_PWRUP;
            phase_q    <= PH_SETUP;
            cnt_q      <= PWRUP_LOAD;
            init_idx_q <= 2'd0;
            col_q      <= 4'd0;
            snap_top_q <= BLANK_ROW;
            snap_bot_q <= BLANK_ROW;
            ready_q    <= 1'b0;
            force_q    <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            init_idx_q <= init_idx_d;
            col_q      <= col_d;
            snap_top_q <= snap_top_d;
            snap_bot_q <= snap_bot_d;
            ready_q    <= ready_d;
            force_q    <= force_d;
            en_q       <= en_d;
        end
    end

    // The strobe comes straight from a flop so the panel never sees a
    // decode glitch on the edge it latches on.
    assign lcd_en   = en_q;
    assign lcd_rs   = byte_rs;
    assign lcd_data = byte_data;
    assign lcd_rw   = 1'b0;
    assign busy     = (state_q != S_IDLE);
    assign ready    = ready_q;

endmodule

// File: tb/tb_host_lcd_sequencer.sv
module tb_host_lcd_sequencer;

    localparam int P_PWRUP = 10;
    localparam int P_EN    = 2;
    localparam int P_BYTE  = 3;
    localparam int P_CLR   = 8;

    localparam logic [127:0] SPACES = {16{8'h20}};

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic [127:0] top;
    logic [127:0] bottom;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_en;
    logic [7:0]   lcd_data;
    logic         busy;
    logic         ready;

    always #5 clk = ~clk;

    host_lcd_sequencer #(
        .PWRUP_CYC (P_PWRUP),
        .EN_CYC    (P_EN),
        .BYTE_CYC  (P_BYTE),
        .CLR_CYC   (P_CLR)
    ) dut (
        .clk      (clk),
        .nRst     (nRst),
        .top      (top),
        .bottom   (bottom),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data),
        .busy     (busy),
        .ready    (ready)
    );

    int errors = 0;
    int checks = 0;

    // Expected byte stream as {rs, data}. It is popped at every strobe fall.
    logic [8:0]   exp_q[$];
    // What the panel will show once every queued byte has been written.
    logic [127:0] disp_top;
    logic [127:0] disp_bot;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the byte sequence the panel must receive.
    function automatic void push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endfunction

    function automatic void push_refresh(input logic [127:0] t, input logic [127:0] b);
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, t[127 - 8*i -: 8]});
        exp_q.push_back(9'h0C0);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, b[127 - 8*i -: 8]});
        disp_top = t;
        disp_bot = b;
    endfunction

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'($urandom_range(126, 32));
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard at each strobe fall. It also times the
    // strobe width, the bus stability during the strobe and the idle gaps.
    // ------------------------------------------------------------------
    logic       prev_en = 1'b0;
    int         hi_cnt = 0;
    int         lo_cnt = 0;
    int         last_kind = 0;  // 1 = clear command, 2 = address command
    logic [8:0] cap;
    logic       moved;
    logic [8:0] got;
    logic [8:0] expv;

    always @(negedge clk) begin
        if (!nRst) begin
            prev_en   = 1'b0;
            hi_cnt    = 0;
            lo_cnt    = 0;
            last_kind = 0;
        end else begin
            if (lcd_en) begin
                if (!prev_en) begin
                    cap   = {lcd_rs, lcd_data};
                    moved = 1'b0;
                    if (last_kind == 1) chk("gap_after_clear", lo_cnt, P_CLR + 1);
                    if (last_kind == 2) chk("gap_after_addr", lo_cnt, P_BYTE + 1);
                    hi_cnt = 0;
                end
                hi_cnt++;
                if ({lcd_rs, lcd_data} !== cap) moved = 1'b1;
            end else begin
                if (prev_en) begin
                    got = {lcd_rs, lcd_data};
                    chk("en_width", hi_cnt, P_EN);
                    chk("strobe_stable", int'(moved), 0);
                    chk("fall_matches_rise", int'(got), int'(cap));
                    chk("rw_low", int'(lcd_rw), 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none at %0t", got, $time);
                    end else begin
                        expv = exp_q.pop_front();
                        chk("byte", int'(got), int'(expv));
                    end
                    last_kind = (got == 9'h001) ? 1 :
                                ((got == 9'h080) || (got == 9'h0C0)) ? 2 : 0;
                    lo_cnt = 0;
                end
                lo_cnt++;
            end
            prev_en = lcd_en;
        end
    end

    // ------------------------------------------------------------------
    // Bounded waits
    // ------------------------------------------------------------------
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !busy && !lcd_en) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", int'(exp_q.size() == 0 && !busy), 1);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_rise", int'(busy), 1);
    endtask

    task automatic apply_idle(input logic [127:0] t, input logic [127:0] b);
        @(negedge clk);
        top    = t;
        bottom = b;
        if (t !== disp_top || b !== disp_bot) push_refresh(t, b);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [127:0] a_top, a_bot, b_top, b_bot, w_top;
    int           kind, en_hits, busy_hits, n;

    initial begin
        top      = SPACES;
        bottom   = SPACES;
        disp_top = SPACES;
        disp_bot = SPACES;
        nRst     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", int'(lcd_en), 0);
        chk("rst_rs", int'(lcd_rs), 0);
        chk("rst_rw", int'(lcd_rw), 0);
        chk("rst_data", int'(lcd_data), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_ready", int'(ready), 0);

        // T1: init, then a forced refresh of the blank rows
        push_init();
        push_refresh(SPACES, SPACES);
        @(negedge clk);
        nRst = 1'b1;
        repeat (5) @(negedge clk);
        chk("pwrup_ready", int'(ready), 0);
        chk("pwrup_busy", int'(busy), 1);
        chk("pwrup_en", int'(lcd_en), 0);
        wait_idle();
        chk("t1_ready", int'(ready), 1);
        chk("t1_busy", int'(busy), 0);

        // T2: one character on line 1
        w_top = SPACES;
        w_top[127:120] = 8'h57;
        apply_idle(w_top, SPACES);
        wait_idle();

        // T3: bottom changes during ROW1 column 5
        a_top = rand_row();
        apply_idle(a_top, disp_bot);
        wait_busy();
        repeat (38) @(negedge clk);
        b_bot  = rand_row();
        bottom = b_bot;
        push_refresh(a_top, b_bot);
        wait_idle();

        // T6: quiet idle
        en_hits   = 0;
        busy_hits = 0;
        repeat (1000) begin
            @(negedge clk);
            if (lcd_en) en_hits++;
            if (busy) busy_hits++;
        end
        chk("idle_no_en", en_hits, 0);
        chk("idle_no_busy", busy_hits, 0);

        // Randomized mix of idle changes, mid-refresh changes and reverts
        for (int it = 0; it < 12; it++) begin
            kind  = $urandom_range(2, 0);
            a_top = ($urandom_range(1, 0) == 1) ? rand_row() : disp_top;
            a_bot = rand_row();
            apply_idle(a_top, a_bot);
            if (kind == 0) begin
                repeat ($urandom_range(20, 0)) @(negedge clk);
            end else begin
                wait_busy();
                repeat ($urandom_range(100, 0)) @(negedge clk);
                b_top = ($urandom_range(1, 0) == 1) ? rand_row() : a_top;
                b_bot = rand_row();
                top    = b_top;
                bottom = b_bot;
                if (kind == 1) begin
                    if (b_top !== a_top || b_bot !== a_bot) push_refresh(b_top, b_bot);
                end else begin
                    // Revert before the refresh ends: no second refresh
                    repeat ($urandom_range(60, 1)) @(negedge clk);
                    top    = a_top;
                    bottom = a_bot;
                end
            end
            wait_idle();
        end

        // T5: reset while strobing in ROW2
        a_top = rand_row();
        apply_idle(a_top, rand_row());
        wait_busy();
        repeat (150) @(negedge clk);
        n = 0;
        while (!lcd_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_en_seen", int'(lcd_en), 1);
        #2;
        nRst = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_en", int'(lcd_en), 0);
        chk("t5_busy", int'(busy), 1);
        chk("t5_ready", int'(ready), 0);
        chk("t5_data", int'(lcd_data), 0);
        push_init();
        push_refresh(top, bottom);
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_pwrup_ready", int'(ready), 0);
        wait_idle();
        chk("t5_ready_again", int'(ready), 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
